// File: rtl/alu_cmd_sequencer.sv
// Purpose : command sequencer for the 16-bit ripple ALU; reads operands from an internal register file, writes the result back, returns a response.
// Latency : accept edge is cycle 0; rsp_valid pulses in cycle 3; rd is written on the edge that ends cycle 2.
// Backpressure: cmd_ready is high only in IDLE, giving at most one command per 4 cycles; cmd_* is ignored while busy.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_rd, cmd_rs1, cmd_rs2 form the command
//   wr_en/wr_addr/wr_data       host preload of a register, accepted in any state
//   alu_a/alu_b/alu_op          registered operands and opcode driven to the external ALU
//   alu_y/alu_carry             combinational ALU result and carry out of bit 15
//   rsp_valid/rsp_data/rsp_carry  one-cycle response; data and carry held until the next response
//   busy                        high whenever the sequencer is not in IDLE
//   flag_z/flag_c               zero and carry flags, present only when ALU_SEQ_FLAGS_EN is defined
//
// Optional feature: define ALU_SEQ_FLAGS_EN to add the flag_z/flag_c outputs and their registers.

module alu_cmd_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_rs1,
    input  logic [RA_W-1:0]   cmd_rs2,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              busy
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] regs [NREG];
    logic              cmd_acc;
    logic              capt;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign capt    = (state == CAPT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = OPER;
                end
            end
            OPER: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are read with pre-edge register contents, so a host write in
    // the accept cycle is not visible to the command being accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rd_q      <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
        end else begin
            if (cmd_acc) begin
                alu_a  <= regs[cmd_rs1];
                alu_b  <= regs[cmd_rs2];
                alu_op <= cmd_op;
                rd_q   <= cmd_rd;
            end
            if (capt) begin
                rsp_data  <= alu_y;
                // Logic ops (op[2]=1) report no carry whatever the ALU drives.
                rsp_carry <= alu_carry & ~alu_op[2];
            end
        end
    end

    // Writeback is placed after the host write so that, for the same
    // address in CAPT, the ALU result is the one that lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (capt) begin
                regs[rd_q] <= alu_y;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (capt) begin
            flag_z <= (alu_y == '0);
            flag_c <= alu_carry & ~alu_op[2];
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose : self-checking bench for alu_cmd_sequencer with a behavioural ALU attached to the operand bus.
// Latency : checks rsp_valid exactly 3 cycles after accept and the back-to-back accept spacing.
// Backpressure: checks that cmd_ready drops while busy and that a held command is taken in cycle 4.

module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_carry;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic        flag_z;
    logic        flag_c;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        c;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [15:0] m [8];
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_c    (flag_c)
`endif
    );

    always #5 clk = ~clk;

    // Ripple ALU stand-in. Logic ops deliberately drive carry=1 so the
    // sequencer's carry masking is exercised.
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + 17'd1;
            3'd2:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
            3'd3:    return {1'b0, a} + 17'h0FFFF;
            3'd4:    return {1'b1, 16'h0000};
            3'd5:    return {1'b1, a | b};
            3'd6:    return {1'b1, a & b};
            default: return {1'b1, a ^ b};
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_y} = alu_f(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        exp_t        e;
        r   = alu_f(op, a, b);
        e.d = r[15:0];
        e.c = op[2] ? 1'b0 : r[16];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data", {16'h0, rsp_data}, {16'h0, mon_e.d});
                chk("rsp_carry", {31'h0, rsp_carry}, {31'h0, mon_e.c});
`ifdef ALU_SEQ_FLAGS_EN
                chk("flag_z", {31'h0, flag_z}, {31'h0, (mon_e.d == 16'h0)});
                chk("flag_c", {31'h0, flag_c}, {31'h0, mon_e.c});
`endif
            end
        end
    end

    task automatic host_wr(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        m[addr] = data;
    endtask

    // wmode: 0 none, 1 host write in the accept cycle, 2 host write during CAPT
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input int wmode, input logic [2:0] waddr,
                           input logic [15:0] wdata);
        exp_t e;
        int   w;
        int   k;
        int   got;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'd1);
        e = expect_of(op, m[rs1], m[rs2]);
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        if (wmode == 1) begin
            wr_en   = 1'b1;
            wr_addr = waddr;
            wr_data = wdata;
        end
        @(posedge clk);
        if (wmode == 1) m[waddr] = wdata;
        m[rd] = e.d;
        k   = 0;
        got = -1;
        while (got < 0 && k < 8) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                cmd_valid = 1'b0;
                wr_en     = 1'b0;
                chk("busy_oper", {31'h0, busy}, 32'd1);
                chk("ready_oper", {31'h0, cmd_ready}, 32'd0);
            end
            if (k == 2 && wmode == 2) begin
                wr_en   = 1'b1;
                wr_addr = waddr;
                wr_data = wdata;
            end
            if (k == 3) wr_en = 1'b0;
            if (rsp_valid) got = k;
        end
        wr_en = 1'b0;
        chk("latency", got, 32'd3);
    endtask

    task automatic back_to_back();
        exp_t e;
        @(negedge clk);
        chk("b2b_ready0", {31'h0, cmd_ready}, 32'd1);
        e = expect_of(3'd0, m[1], m[2]);
        sb.push_back(e);
        m[3] = e.d;
        cmd_valid = 1'b1;
        cmd_op = 3'd0; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                e = expect_of(3'd2, m[3], m[1]);
                sb.push_back(e);
                m[4] = e.d;
                cmd_op = 3'd2; cmd_rd = 3'd4; cmd_rs1 = 3'd3; cmd_rs2 = 3'd1;
            end
            if (k <= 4) chk("b2b_ready", {31'h0, cmd_ready}, {31'h0, (k == 4)});
            chk("b2b_rsp", {31'h0, rsp_valid}, {31'h0, (k == 3 || k == 7)});
            if (k == 5) cmd_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_cmd();
        @(negedge clk);
        chk("rst_pre_ready", {31'h0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op = 3'd0; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        end
        chk("rst_alu_a", {16'h0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'h0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'h0, alu_op}, 32'd0);
        chk("rst_rsp_data", {16'h0, rsp_data}, 32'd0);
        chk("rst_rsp_carry", {31'h0, rsp_carry}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_flag_z", {31'h0, flag_z}, 32'd0);
        chk("rst_flag_c", {31'h0, flag_c}, 32'd0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready_after", {31'h0, cmd_ready}, 32'd1);
        chk("rst_no_rsp_after", {31'h0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'h0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {16'h0, rsp_data}, 32'd0);
        chk("reset_alu_op", {29'h0, alu_op}, 32'd0);
        rst_n = 1'b1;

        host_wr(3'd1, 16'h0005);
        host_wr(3'd2, 16'h0003);
        run_cmd(3'd2, 3'd3, 3'd1, 3'd2, 0, 3'd0, 16'h0);   // SUB 5-3
        run_cmd(3'd5, 3'd5, 3'd3, 3'd3, 0, 3'd0, 16'h0);   // OR reads back R3
        host_wr(3'd1, 16'hFFFF);
        host_wr(3'd2, 16'h0001);
        run_cmd(3'd0, 3'd6, 3'd1, 3'd2, 0, 3'd0, 16'h0);   // ADD wraps to 0, carry 1
        run_cmd(3'd3, 3'd4, 3'd4, 3'd4, 0, 3'd0, 16'h0);   // DEC 0 -> FFFF, carry 0
        run_cmd(3'd7, 3'd7, 3'd4, 3'd1, 0, 3'd0, 16'h0);   // XOR FFFF^FFFF
        run_cmd(3'd1, 3'd0, 3'd1, 3'd1, 0, 3'd0, 16'h0);   // INC FFFF
        run_cmd(3'd6, 3'd2, 3'd4, 3'd5, 0, 3'd0, 16'h0);   // AND
        run_cmd(3'd4, 3'd1, 3'd4, 3'd4, 0, 3'd0, 16'h0);   // ZERO

        host_wr(3'd1, 16'h0009);
        host_wr(3'd2, 16'h0004);
        back_to_back();

        host_wr(3'd6, 16'h0007);
        run_cmd(3'd0, 3'd5, 3'd6, 3'd6, 1, 3'd6, 16'h0100); // host write to rs1 at accept
        run_cmd(3'd5, 3'd5, 3'd6, 3'd6, 0, 3'd0, 16'h0);     // host write did land

        host_wr(3'd1, 16'h0050);
        host_wr(3'd2, 16'h0020);
        run_cmd(3'd2, 3'd2, 3'd1, 3'd2, 2, 3'd2, 16'h1234); // host write to rd in CAPT loses
        run_cmd(3'd5, 3'd0, 3'd2, 3'd2, 0, 3'd0, 16'h0);

        reset_mid_cmd();
        run_cmd(3'd5, 3'd5, 3'd1, 3'd2, 0, 3'd0, 16'h0);   // registers cleared
        run_cmd(3'd1, 3'd5, 3'd5, 3'd5, 0, 3'd0, 16'h0);

        for (int n = 0; n < 24; n++) begin
            logic [2:0] rd;
            int         wm;
            if ($urandom_range(1, 0) == 1) host_wr(3'($urandom_range(7, 0)), 16'($urandom));
            rd = 3'($urandom_range(7, 0));
            wm = $urandom_range(2, 0);
            run_cmd(3'($urandom_range(7, 0)), rd, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    wm, (wm == 2) ? rd : 3'($urandom_range(7, 0)), 16'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            run_cmd(3'd5, 3'(i), 3'(i), 3'(i), 0, 3'd0, 16'h0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
